// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module     : store_buffer_if
// Purpose    : Bundles the CPU store/load handshakes and the data-memory port
//              of the posted-write store buffer.
// Ports      : master - CPU + data memory side (drives requests, MemDataOut)
//              slave  - store buffer side (drives ready/forwarding/memory ctrl)
// Revision   : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  // CPU store side
  logic          StReq;
  logic [AW-1:0] StAddr;
  logic [DW-1:0] StData;
  logic          StReady;
  // CPU load side
  logic          LdReq;
  logic [AW-1:0] LdAddr;
  logic          LdReady;
  logic [DW-1:0] LdData;
  logic          LdHit;
  // data memory port
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemDataIn;
  logic          MemW;
  logic          MemR;
  logic [DW-1:0] MemDataOut;
  // occupancy
  logic [CW-1:0] Count;
  logic          Empty;

  modport slave (
    input  StReq, StAddr, StData, LdReq, LdAddr, MemDataOut,
    output StReady, LdReady, LdData, LdHit, MemAddr, MemDataIn, MemW, MemR,
           Count, Empty
  );

  modport master (
    output StReq, StAddr, StData, LdReq, LdAddr, MemDataOut,
    input  StReady, LdReady, LdData, LdHit, MemAddr, MemDataIn, MemW, MemR,
           Count, Empty
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module     : store_buffer
// Purpose    : Posted-write FIFO between the CPU memory stage and the data
//              memory. Stores are queued and drained one per cycle whenever
//              the memory port is not used by a load; loads forward from the
//              youngest matching queued store; a starvation counter forces a
//              drain after STARVE_MAX consecutive load-blocked cycles.
// Ports      : CLK - clock (posedge)
//              RST - asynchronous active-high reset
//              sb  - store_buffer_if.slave (store/load handshakes, memory
//                    port, Count/Empty status)
// Revision   : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic           CLK,
  input  logic           RST,
  store_buffer_if.slave  sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] C_DEPTH       = CW'(DEPTH);
  localparam logic [SW-1:0] C_STARVE_LAST = SW'(STARVE_MAX - 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          force_q, force_d;

  logic          empty, force_cycle, push, pop, ld_serviced;
  logic          st_ready, ld_ready, ld_hit, mem_w, mem_r;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, ld_data;
  logic [PW-1:0] idx;

  // Port arbitration, pointer/occupancy and starvation next-state
  always_comb begin
    empty       = (count_q == '0);
    force_cycle = force_q && !empty;
    // Readiness looks only at the registered count: a same-cycle pop never
    // frees a slot for a push.
    st_ready    = (count_q < C_DEPTH);
    push        = sb.StReq && st_ready;

    ld_ready = 1'b1;
    mem_w    = 1'b0;
    mem_r    = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    pop      = 1'b0;

    if (force_cycle) begin
      ld_ready = 1'b0;
      mem_w    = 1'b1;
      mem_addr = addr_q[head_q];
      mem_din  = data_q[head_q];
      pop      = 1'b1;
    end else if (sb.LdReq) begin
      mem_r    = 1'b1;
      mem_addr = sb.LdAddr;
    end else if (!empty) begin
      mem_w    = 1'b1;
      mem_addr = addr_q[head_q];
      mem_din  = data_q[head_q];
      pop      = 1'b1;
    end

    ld_serviced = sb.LdReq && ld_ready;

    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);

    // Force is a one-cycle pulse raised on the load that would take the
    // counter past STARVE_MAX-1; the forced pop then clears the counter.
    force_d  = 1'b0;
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (ld_serviced) begin
      if (starve_q == C_STARVE_LAST) begin
        starve_d = '0;
        force_d  = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Load forwarding: walk from oldest (head) to youngest so the last match
  // wins. Uses registered state only, so a same-cycle push is invisible and
  // an entry popped this cycle still forwards.
  always_comb begin
    ld_data = sb.MemDataOut;
    ld_hit  = 1'b0;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((i < int'(count_q)) && (addr_q[idx] == sb.LdAddr)) begin
        ld_data = data_q[idx];
        ld_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      force_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      force_q  <= force_d;
    end
  end

  // Entry storage needs no reset: validity is defined by head/count.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail_q] <= sb.StAddr;
      data_q[tail_q] <= sb.StData;
    end
  end

  assign sb.StReady   = st_ready;
  assign sb.LdReady   = ld_ready;
  assign sb.LdData    = ld_data;
  assign sb.LdHit     = ld_hit;
  assign sb.MemAddr   = mem_addr;
  assign sb.MemDataIn = mem_din;
  assign sb.MemW      = mem_w;
  assign sb.MemR      = mem_r;
  assign sb.Count     = count_q;
  assign sb.Empty     = empty;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module     : tb_store_buffer
// Purpose    : Self-checking bench for store_buffer: a table of per-cycle
//              vectors for push/drain/forwarding, plus directed sequences for
//              full buffer, starvation-forced drain and async reset.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  store_buffer_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(5), .DW(32), .STARVE_MAX(8)) dut (
    .CLK (clk),
    .RST (rst),
    .sb  (bus)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write on posedge.
  logic [31:0] mem [0:31] = '{default: '0};
  always @(posedge clk) begin
    if (bus.MemW) mem[bus.MemAddr] <= bus.MemDataIn;
  end
  assign bus.MemDataOut = mem[bus.MemAddr];

  typedef struct {
    logic        st_req;
    logic [4:0]  st_addr;
    logic [31:0] st_data;
    logic        ld_req;
    logic [4:0]  ld_addr;
    logic [79:0] exp;
  } vec_t;

  vec_t vecs [14];

  // Layout: {pad, StReady, LdReady, LdData, LdHit, MemW, MemR, MemAddr,
  //          MemDataIn, Count, Empty}
  function automatic logic [79:0] expv(logic sr, logic lr, logic [31:0] ld,
                                        logic hit, logic w, logic r,
                                        logic [4:0] a, logic [31:0] d,
                                        logic [2:0] c);
    return {2'b00, sr, lr, ld, hit, w, r, a, d, c, (c == 3'd0)};
  endfunction

  function automatic logic [79:0] snap();
    return {2'b00, bus.StReady, bus.LdReady, bus.LdData, bus.LdHit, bus.MemW,
            bus.MemR, bus.MemAddr, bus.MemDataIn, bus.Count, bus.Empty};
  endfunction

  function automatic vec_t mk(logic sq, logic [4:0] sa, logic [31:0] sd,
                              logic lq, logic [4:0] la, logic [79:0] e);
    vec_t v;
    v.st_req = sq; v.st_addr = sa; v.st_data = sd;
    v.ld_req = lq; v.ld_addr = la; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic sq, input logic [4:0] sa,
                       input logic [31:0] sd, input logic lq,
                       input logic [4:0] la);
    bus.StReq  = sq;
    bus.StAddr = sa;
    bus.StData = sd;
    bus.LdReq  = lq;
    bus.LdAddr = la;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, expv(1, 1, 32'h0,        0, 0, 0, 0, 32'h0,        0));
    vecs[1]  = mk(1, 3, 32'hDEADBEEF, 0, 0, expv(1, 1, 32'h0,        0, 0, 0, 0, 32'h0,        0));
    vecs[2]  = mk(0, 0, 32'h0,        0, 0, expv(1, 1, 32'h0,        0, 1, 0, 3, 32'hDEADBEEF, 1));
    vecs[3]  = mk(0, 0, 32'h0,        1, 3, expv(1, 1, 32'hDEADBEEF, 0, 0, 1, 3, 32'h0,        0));
    vecs[4]  = mk(1, 9, 32'hAA,       1, 9, expv(1, 1, 32'h0,        0, 0, 1, 9, 32'h0,        0));
    vecs[5]  = mk(0, 0, 32'h0,        1, 9, expv(1, 1, 32'hAA,       1, 0, 1, 9, 32'h0,        1));
    vecs[6]  = mk(1, 5, 32'h11,       1, 5, expv(1, 1, 32'h0,        0, 0, 1, 5, 32'h0,        1));
    vecs[7]  = mk(1, 5, 32'h22,       1, 5, expv(1, 1, 32'h11,       1, 0, 1, 5, 32'h0,        2));
    vecs[8]  = mk(0, 0, 32'h0,        1, 5, expv(1, 1, 32'h22,       1, 0, 1, 5, 32'h0,        3));
    vecs[9]  = mk(0, 0, 32'h0,        0, 5, expv(1, 1, 32'h22,       1, 1, 0, 9, 32'hAA,       3));
    vecs[10] = mk(0, 0, 32'h0,        0, 5, expv(1, 1, 32'h22,       1, 1, 0, 5, 32'h11,       2));
    vecs[11] = mk(0, 0, 32'h0,        0, 5, expv(1, 1, 32'h22,       1, 1, 0, 5, 32'h22,       1));
    vecs[12] = mk(0, 0, 32'h0,        1, 5, expv(1, 1, 32'h22,       0, 0, 1, 5, 32'h0,        0));
    vecs[13] = mk(0, 0, 32'h0,        0, 0, expv(1, 1, 32'h0,        0, 0, 0, 0, 32'h0,        0));

    drive(0, 0, 0, 0, 0);
    #12;
    check("reset_state", snap(), expv(1, 1, 32'h0, 0, 0, 0, 0, 32'h0, 0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven: one vector per cycle, outputs sampled mid-cycle.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].st_req, vecs[i].st_addr, vecs[i].st_data,
            vecs[i].ld_req, vecs[i].ld_addr);
      #3;
      check($sformatf("vec%0d", i), snap(), vecs[i].exp);
      @(posedge clk); #1;
    end

    // Fill under continuous loads of address 7.
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(k + 1), 32'h101 + 32'(k), 1, 7);
      #3;
      if (k == 3) check("fourth_push_ready", {76'h0, bus.StReady, bus.Count}, {76'h0, 1'b1, 3'd3});
      @(posedge clk); #1;
    end
    // Fifth store held; loads keep winning until the starve limit.
    drive(1, 6, 32'h106, 1, 7);
    for (int c = 4; c < 9; c++) begin
      #3;
      check($sformatf("full_load_cycle%0d", c),
            {74'h0, bus.LdReady, bus.MemW, bus.StReady, bus.Count},
            {74'h0, 1'b1, 1'b0, 1'b0, 3'd4});
      @(posedge clk); #1;
    end
    #3;
    check("forced_drain",
          {2'b0, bus.LdReady, bus.MemW, bus.MemR, bus.MemAddr, bus.MemDataIn, bus.StReady, bus.Count},
          {2'b0, 1'b0, 1'b1, 1'b0, 5'd1, 32'h101, 1'b0, 3'd4} | 80'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 7);
    #3;
    check("loads_resume",
          {76'h0, bus.LdReady, bus.MemW, bus.MemR, bus.Count} >> 0,
          {76'h0, 1'b1, 1'b0, 1'b1, 3'd3} >> 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("drained_empty", {76'h0, bus.Empty, bus.Count}, {76'h0, 1'b1, 3'd0});
    for (int k = 0; k < 4; k++)
      check($sformatf("mem_word%0d", k + 1), {48'h0, mem[k + 1]}, {48'h0, 32'h101 + 32'(k)});
    check("refused_store_absent", {48'h0, mem[6]}, 80'h0);

    // Async reset with three entries still queued mid-drain.
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(10 + k), 32'hA0 + 32'(k), 1, 7);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("mid_drain_count", {77'h0, bus.Count}, {77'h0, 3'd3});
    #1;
    rst = 1'b1;
    #1;
    check("async_reset",
          {75'h0, bus.Count, bus.MemW, bus.StReady, bus.Empty, bus.LdReady},
          {75'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1});
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("drained_before_reset", {48'h0, mem[10]}, {48'h0, 32'hA0});
    for (int k = 11; k < 14; k++)
      check($sformatf("discarded_word%0d", k), {48'h0, mem[k]}, 80'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
`default_nettype wire
